// File: rtl/rc4_wb_host_port.sv
// Wishbone classic responder feeding the RC4 core: key register file streamed on a valid/ready channel, TX/RX byte FIFOs.
// Ack one cycle after the transfer is sampled; stream channels stall on ready, full FIFOs drop and set sticky overflow flags.

module rc4_wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rp];
  assign do_pop  = pop && !empty;
  // a push into a full FIFO is accepted only when a pop frees the slot in the same cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= din;
  end
endmodule

module rc4_wb_host_port #(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  key_byte_o,
  output logic        key_valid_o,
  output logic        key_last_o,
  input  logic        key_ready_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        irq_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [3:0]  keylen_m1;
  logic [7:0]  key [16];
  logic        key_done, tx_ovf, rx_ovf, key_busy;
  logic        hit, xfer, wr, rd;
  logic [2:0]  off;
  logic [1:0]  kw;
  logic [31:0] rdata;
  logic [7:0]  status;
  logic        ctrl_wr, status_wr, key_wr, start, flush;
  logic        tx_push, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_head, rx_head;
  logic        unused_ok;

  assign unused_ok = ^wbs_adr_i[1:0];

  assign hit  = (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  assign xfer = wbs_stb_i && wbs_cyc_i && hit && !wbs_ack_o;
  assign wr   = xfer && wbs_we_i;
  assign rd   = xfer && !wbs_we_i;
  assign off  = wbs_adr_i[4:2];
  assign kw   = 2'(off - 3'd2);

  assign key_busy  = (state != IDLE);
  assign ctrl_wr   = wr && (off == 3'd0) && wbs_sel_i[0];
  assign status_wr = wr && (off == 3'd1);
  assign key_wr    = wr && (off >= 3'd2) && (off <= 3'd5) && !key_busy;
  assign start     = ctrl_wr && wbs_dat_i[0];
  assign flush     = ctrl_wr && wbs_dat_i[1];
  assign tx_push   = wr && (off == 3'd6) && wbs_sel_i[0];
  assign rx_push   = rx_valid_i && !rx_full;
  assign rx_pop    = rd && (off == 3'd7);

  assign status = {rx_ovf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full, key_done, key_busy};

  always_comb begin
    rdata = 32'h0;
    case (off)
      3'd0: rdata = {24'h0, keylen_m1, 4'h0};
      3'd1: rdata = {24'h0, status};
      3'd2, 3'd3, 3'd4, 3'd5:
        rdata = {key[{kw, 2'd3}], key[{kw, 2'd2}], key[{kw, 2'd1}], key[{kw, 2'd0}]};
      3'd7: rdata = {23'h0, !rx_empty, rx_empty ? 8'h00 : rx_head};
      default: rdata = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
    end else begin
      wbs_ack_o <= xfer;
      wbs_dat_o <= rd ? rdata : 32'h0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      for (int i = 0; i < 16; i++) key[i] <= 8'h0;
      keylen_m1 <= 4'hF;
    end else begin
      if (key_wr) begin
        for (int l = 0; l < 4; l++)
          if (wbs_sel_i[l]) key[{kw, 2'(l)}] <= wbs_dat_i[8*l +: 8];
      end
      // the key length cannot move under a stream in progress
      if (ctrl_wr && !key_busy) keylen_m1 <= wbs_dat_i[7:4];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state    <= IDLE;
      idx      <= 4'h0;
      key_done <= 1'b0;
    end else begin
      if (status_wr) key_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= SEND;
          idx      <= 4'h0;
          key_done <= 1'b0;
        end
        SEND: if (key_ready_i) begin
          if (idx == keylen_m1) state <= DONE;
          else                  idx   <= idx + 4'd1;
        end
        DONE: begin
          key_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (status_wr) begin
        tx_ovf <= 1'b0;
        rx_ovf <= 1'b0;
      end
      if (tx_push && tx_full && !tx_ready_i && !flush) tx_ovf <= 1'b1;
      if (rx_valid_i && rx_full && !flush)             rx_ovf <= 1'b1;
    end
  end

  rc4_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(wb_clk_i), .rst_n(wb_rst_i), .flush(flush),
    .push(tx_push), .pop(tx_ready_i), .din(wbs_dat_i[7:0]),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  rc4_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(wb_clk_i), .rst_n(wb_rst_i), .flush(flush),
    .push(rx_push), .pop(rx_pop), .din(rx_byte_i),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );

  assign key_valid_o = (state == SEND);
  assign key_byte_o  = key_valid_o ? key[idx] : 8'h00;
  assign key_last_o  = key_valid_o && (idx == keylen_m1);
  assign tx_valid_o  = !tx_empty;
  assign tx_byte_o   = tx_empty ? 8'h00 : tx_head;
  // held low while reset is asserted so every output reads 0 in reset
  assign rx_ready_o  = wb_rst_i && !rx_full;
  assign irq_o       = key_done || !rx_empty;
endmodule
